// File: rtl/data_memory_responder_pkg.sv
// Shared types, constants and the address-legality helper for the data memory responder.
package data_memory_responder_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // One captured load/store request.
    typedef struct packed {
        logic                  write;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [WORD_BYTES-1:0] wstrb;
    } mem_req_t;

    // Misaligned byte address or word index past the end of the array.
    // Upper address bits are compared in full, so nothing wraps.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[ADDR_W-1:2]) >= depth);
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response channel between the CPU datapath (master) and the data memory (slave).
//   req_*  : valid/ready load/store request, byte address, store data and byte strobes
//   resp_* : valid/ready response carrying load data and an error flag
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [WORD_BYTES-1:0] req_wstrb;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/data_memory_array.sv
// Word-wide synchronous RAM with byte-strobed writes and a registered read port.
//   clk, reset : clock and synchronous active-low reset (clears only the read register)
//   we, wstrb  : write enable and per-byte enables
//   re, rd_clr : load the read register from memory / clear it to zero
//   addr       : word index shared by read and write
//   wdata      : write data; rdata : registered read data
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] wstrb,
    input  logic                  re,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage is never cleared; only strobed bytes change.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
            if (we && wstrb[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read register holds its value until the next read or clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory responder: accepts one load/store at a time, commits it
// LATENCY cycles after acceptance and holds the response until it is taken.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : slave side of the request/response channel
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t       state, next_state;
    mem_req_t         req_q, in_req_c, cur_req_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, resp_valid_q, resp_error_q;
    logic             accept_c, commit_c, handshake_c, err_c;
    logic             mem_we_c, mem_re_c;

    always_comb begin
        in_req_c.write = bus.req_write;
        in_req_c.addr  = bus.req_addr;
        in_req_c.wdata = bus.req_wdata;
        in_req_c.wstrb = bus.req_wstrb;
    end

    // With LATENCY==1 the commit edge is the acceptance edge, so use the live request.
    assign cur_req_c = (state == IDLE) ? in_req_c : req_q;
    assign err_c     = addr_error(cur_req_c.addr, DEPTH_WORDS);

    // Next-state, counter and commit/handshake strobes.
    always_comb begin
        next_state  = state;
        cnt_d       = cnt_q;
        commit_c    = 1'b0;
        handshake_c = 1'b0;
        accept_c    = (state == IDLE) && req_ready_q && bus.req_valid;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        next_state = WAIT;
                    end else begin
                        next_state = RESP;
                        commit_c   = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    next_state = RESP;
                    commit_c   = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    next_state  = IDLE;
                    handshake_c = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset on the commit edge wins: a pending access never reaches the array.
    assign mem_we_c = reset && commit_c &&  cur_req_c.write && !err_c;
    assign mem_re_c = reset && commit_c && !cur_req_c.write && !err_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state        <= next_state;
            cnt_q        <= cnt_d;
            req_ready_q  <= (next_state == IDLE);
            resp_valid_q <= (next_state == RESP);
            if (commit_c) begin
                resp_error_q <= err_c;
            end else if (handshake_c) begin
                resp_error_q <= 1'b0;
            end
        end
    end

    // Request capture; later changes on req_* are ignored.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            req_q <= in_req_c;
        end
    end

    data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we_c),
        .wstrb  (cur_req_c.wstrb),
        .re     (mem_re_c),
        .rd_clr (handshake_c),
        .addr   (cur_req_c.addr[IDX_W+1:2]),
        .wdata  (cur_req_c.wdata),
        .rdata  (bus.resp_rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (LATENCY=2 and LATENCY=1) share the
// stimulus bus, only the selected one sees req_valid. Checked against a word-array model.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        o_req_ready, o_resp_valid, o_resp_error;
    logic [31:0] o_resp_rdata;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] model [2][DEPTH];
    logic [3:0]  known [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder_if bus2 ();
    data_memory_responder_if bus1 ();

    assign bus2.req_valid  = req_valid && !sel;
    assign bus2.req_write  = req_write;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.req_wstrb  = req_wstrb;
    assign bus2.resp_ready = resp_ready;
    assign bus1.req_valid  = req_valid && sel;
    assign bus1.req_write  = req_write;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.req_wstrb  = req_wstrb;
    assign bus1.resp_ready = resp_ready;

    assign o_req_ready  = sel ? bus1.req_ready  : bus2.req_ready;
    assign o_resp_valid = sel ? bus1.resp_valid : bus2.resp_valid;
    assign o_resp_rdata = sel ? bus1.resp_rdata : bus2.resp_rdata;
    assign o_resp_error = sel ? bus1.resp_error : bus2.resp_error;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .bus(bus2));
    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full transaction; called #1 after a rising edge with the target idle.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int bp,
                        output logic [31:0] rd, output logic er, output int lat, output int acc);
        int k;
        rd = '0; er = 1'b0; lat = -1; acc = cyc;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1; resp_ready = 1'b0;
        k = 0;
        while (!o_req_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!o_req_ready) begin
            check("accept_timeout", 32'(o_req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        // Scramble the request lines: they must not affect the accepted access.
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'hF;
        resp_ready = (bp == 0);
        lat = 1;
        while (!o_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!o_resp_valid) begin
            check("resp_timeout", 32'(o_resp_valid), 32'd1);
            lat = -1;
            return;
        end
        rd = o_resp_rdata; er = o_resp_error;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(o_resp_valid), 32'd1);
            check("bp_rdata", o_resp_rdata, rd);
            check("bp_error", 32'(o_resp_error), 32'(er));
            check("bp_req_ready", 32'(o_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(o_resp_valid), 32'd0);
        check("post_rdata", o_resp_rdata, 32'd0);
        check("post_error", 32'(o_resp_error), 32'd0);
        check("post_req_ready", 32'(o_req_ready), 32'd1);
    endtask

    // Transaction checked against the model: error rule, latency, load data on known bytes.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int bp,
                           output logic [31:0] rd, output logic er, output int acc);
        int          inst, idx, lat;
        logic        exp_err;
        logic [31:0] exp_rd, mask;
        inst    = sel ? 1 : 0;
        exp_err = (a % 4 != 0) || (a / 4 >= DEPTH);
        idx     = exp_err ? 0 : int'(a / 4);
        exp_rd  = '0;
        mask    = '1;
        if (!w && !exp_err) begin
            exp_rd = model[inst][idx];
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = known[inst][idx][b] ? 8'hFF : 8'h00;
        end
        xact(w, a, d, s, bp, rd, er, lat, acc);
        check("latency", 32'(lat), sel ? 32'd1 : 32'd2);
        check("error", 32'(er), 32'(exp_err));
        check("rdata", rd & mask, exp_rd & mask);
        if (w && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    model[inst][idx][8*b +: 8] = d[8*b +: 8];
                    known[inst][idx][b] = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc, prev;
        logic        w;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) for (int j = 0; j < int'(DEPTH); j++) begin
            model[i][j] = '0; known[i][j] = 4'h0;
        end
        vecs[0]  = '{1'b1, 32'h10,       32'hdeadbeef, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hdeadbeef, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hde22be44, 1'b0};
        vecs[4]  = '{1'b1, 32'h0,        32'ha5a5a5a5, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h12,       32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h400,      32'hffffffff, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'ha5a5a5a5, 1'b0};
        vecs[8]  = '{1'b1, 32'h3FC,      32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h3FC,      32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[10] = '{1'b1, 32'h8,        32'hcafebabe, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'h8,        32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h8,        32'h0,        4'h0, 32'hcafebabe, 1'b0};
        vecs[13] = '{1'b0, 32'h80000010, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h13,       32'h99999999, 4'hF, 32'h0,        1'b1};

        reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(o_req_ready), 32'd0);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_rdata", o_resp_rdata, 32'd0);
        check("rst_error", 32'(o_resp_error), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", 32'(o_req_ready), 32'd1);

        // Table-driven directed vectors on the LATENCY=2 instance
        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 0, rd, er, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Back-pressure for 3 cycles
        run_req(1'b0, 32'h10, 32'h0, 4'h0, 3, rd, er, acc);
        check("bp_load_rdata", rd, 32'hde22be44);

        // Reset while the store sits in WAIT
        run_req(1'b1, 32'h20, 32'h01234567, 4'hF, 0, rd, er, acc);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hcafef00d; req_wstrb = 4'hF;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_req_ready", 32'(o_req_ready), 32'd0);
        check("wait_resp_valid", 32'(o_resp_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw_req_ready", 32'(o_req_ready), 32'd0);
        check("rstw_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rstw_rdata", o_resp_rdata, 32'd0);
        check("rstw_error", 32'(o_resp_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstw_rel_ready", 32'(o_req_ready), 32'd1);
        run_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, acc);
        check("rstw_load", rd, 32'h01234567);

        // Reset while the store's response is outstanding: store already committed
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h5a5a1234; req_wstrb = 4'hF;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("resp_pending", 32'(o_resp_valid), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstr_resp_valid", 32'(o_resp_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        model[0][9] = 32'h5a5a1234; known[0][9] = 4'hF;
        run_req(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er, acc);
        check("rstr_load", rd, 32'h5a5a1234);

        // Back-to-back on the LATENCY=1 instance
        sel = 1'b1;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            a = 32'(8 * (i / 2));
            w = (i % 2 == 0);
            run_req(w, a, 32'h1000_0000 + 32'(i * 32'h01010101), 4'hF, 0, rd, er, acc);
            if (!w) check($sformatf("b2b_load%0d", i), rd, 32'h1000_0000 + 32'((i - 1) * 32'h01010101));
            if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end

        // Randomized traffic on both instances
        for (int n = 0; n < 200; n++) begin
            int r;
            sel = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom | 32'h1;
            else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h400;
            else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
            run_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                    rd, er, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
